// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared helpers for the AXI-Stream width up-converter:
//   clog2_min1 - index register width, never narrower than one bit
//   dw_out     - packed output word width (DW_IN * RATIO)
//   lane_of    - maps a beat position within a word to its output lane
// No ports; imported by the upsizer interface and modules.
// ---------------------------------------------------------------------------
package axis_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int dw_out(input int dw_in, input int ratio);
        return dw_in * ratio;
    endfunction

    // Beat position idx goes to lane idx when filling from the low end,
    // otherwise the word is filled from the top lane downwards.
    function automatic int lane_of(input int idx, input bit lsb_first, input int ratio);
        return lsb_first ? idx : (ratio - 1 - idx);
    endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// ---------------------------------------------------------------------------
// axis_upsizer_if
// Bundles both stream sides of the up-converter.
//   s_tdata/s_tvalid/s_tlast -> upsizer, s_tready <- upsizer (narrow side)
//   m_tdata/m_tkeep/m_tvalid/m_tlast <- upsizer, m_tready -> upsizer (wide side)
// Modports:
//   slave  - the upsizer's view (consumes the narrow stream, sources the wide one)
//   master - the surrounding system's view (producer + consumer)
// ---------------------------------------------------------------------------
interface axis_upsizer_if
    import axis_pkg::*;
#(
    parameter int DW_IN = 8,
    parameter int RATIO = 4
);
    logic [DW_IN-1:0]               s_tdata;
    logic                           s_tvalid;
    logic                           s_tready;
    logic                           s_tlast;
    logic [dw_out(DW_IN, RATIO)-1:0] m_tdata;
    logic [RATIO-1:0]               m_tkeep;
    logic                           m_tvalid;
    logic                           m_tready;
    logic                           m_tlast;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axis_out_reg.sv
// ---------------------------------------------------------------------------
// axis_out_reg
// Output holding register with valid/ready hold logic, generic in width.
//   clk, reset_n - clock, asynchronous active-low reset (clears data too)
//   load         - capture in_data; only asserted while can_load is high
//   in_data      - word to capture
//   out_ready    - downstream ready
//   out_valid    - register holds a word not yet taken
//   out_data     - held word, stable while out_valid && !out_ready
//   can_load     - register is empty or drains this cycle
// ---------------------------------------------------------------------------
module axis_out_reg
    import axis_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    assign can_load = !out_valid || out_ready;

    // A load in the same cycle as a drain replaces the word and keeps
    // valid high, giving back-to-back words without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsizer.sv
// ---------------------------------------------------------------------------
// axis_upsizer
// AXI-Stream width up-converter: packs RATIO beats of DW_IN bits into one
// DW_IN*RATIO-bit word with per-lane keep and tlast framing.
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - axis_upsizer_if.slave: narrow s_* input stream, wide m_* output
// Note: s_tready is combinational from m_tready (ready passes straight
// through when the output register is full and draining).
// ---------------------------------------------------------------------------
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int DW_IN     = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    axis_upsizer_if.slave      bus
);

    localparam int DW_OUT = dw_out(DW_IN, RATIO);
    localparam int IDX_W  = clog2_min1(RATIO);
    localparam int REG_W  = DW_OUT + RATIO + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  lane;
    logic [DW_OUT-1:0] acc_data;
    logic [RATIO-1:0]  acc_keep;
    logic [DW_OUT-1:0] merged_data;
    logic [RATIO-1:0]  merged_keep;
    logic              can_load;
    logic              accept;
    logic              complete;
    logic [REG_W-1:0]  reg_q;

    assign bus.s_tready = reset_n && can_load;
    assign accept       = bus.s_tvalid && bus.s_tready;
    assign complete     = accept && ((idx == IDX_LAST) || bus.s_tlast);
    assign lane         = IDX_W'(lane_of(int'(idx), LSB_FIRST != 0, RATIO));

    // Current beat merged into the accumulator; lanes never written stay 0
    // because the accumulator is cleared at every word boundary.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int l = 0; l < RATIO; l++) begin
            if (lane == IDX_W'(l)) begin
                merged_data[l*DW_IN +: DW_IN] = bus.s_tdata;
                merged_keep[l]                = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (complete) begin
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            idx      <= idx + IDX_W'(1);
            acc_data <= merged_data;
            acc_keep <= merged_keep;
        end
    end

    axis_out_reg #(
        .W (REG_W)
    ) u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (complete),
        .in_data   ({bus.s_tlast, merged_keep, merged_data}),
        .out_ready (bus.m_tready),
        .out_valid (bus.m_tvalid),
        .out_data  (reg_q),
        .can_load  (can_load)
    );

    assign {bus.m_tlast, bus.m_tkeep, bus.m_tdata} = reg_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// ---------------------------------------------------------------------------
// tb_axis_upsizer
// Drives two upsizers (LSB_FIRST=1 and LSB_FIRST=0) with one shared stream.
// Directed vector table, hand-written multi-cycle sequences and a random
// phase checked against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_axis_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    axis_upsizer_if #(.DW_IN(DW), .RATIO(R)) b1 ();
    axis_upsizer_if #(.DW_IN(DW), .RATIO(R)) b0 ();

    axis_upsizer #(.DW_IN(DW), .RATIO(R), .LSB_FIRST(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    axis_upsizer #(.DW_IN(DW), .RATIO(R), .LSB_FIRST(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    int n_pass  = 0;
    int n_total = 0;
    int stall_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        b1.s_tvalid = v; b1.s_tdata = d; b1.s_tlast = l;
        b0.s_tvalid = v; b0.s_tdata = d; b0.s_tlast = l;
    endtask

    task automatic set_ready(input logic r);
        b1.m_tready = r;
        b0.m_tready = r;
    endtask

    // Present one beat, wait (bounded) for s_tready, return #1 after the
    // edge that transferred it.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int waits;
        waits = 0;
        drive(1'b1, d, l);
        #1;
        while (!b1.s_tready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 50) begin
            n_total++;
            $display("FAIL send_timeout: s_tready low for %0d cycles, required high", waits);
        end
        stall_cnt += waits;
        @(posedge clk); #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t       q1[$];
    word_t       q0[$];
    logic [7:0]  part[$];
    word_t       w1, w0, e1, e0, held1;
    logic        stall1 = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            part.delete();
            q1.delete();
            q0.delete();
            stall1 = 1'b0;
        end else begin
            check("s_tready_rule1", b1.s_tready, !b1.m_tvalid || b1.m_tready);
            check("s_tready_rule0", b0.s_tready, !b0.m_tvalid || b0.m_tready);
            if (stall1) begin
                check("hold_valid", b1.m_tvalid, 1'b1);
                check("hold_data", b1.m_tdata, held1.d);
                check("hold_keep", b1.m_tkeep, held1.k);
                check("hold_last", b1.m_tlast, held1.l);
            end
            if (b1.s_tvalid && b1.s_tready) begin
                part.push_back(b1.s_tdata);
                if (b1.s_tlast || part.size() == R) begin
                    w1 = '{32'h0, 4'h0, b1.s_tlast};
                    w0 = '{32'h0, 4'h0, b1.s_tlast};
                    for (int j = 0; j < part.size(); j++) begin
                        w1.d |= 32'(part[j]) << (8 * j);
                        w1.k |= 4'(1) << j;
                        w0.d |= 32'(part[j]) << (8 * (R - 1 - j));
                        w0.k |= 4'(1) << (R - 1 - j);
                    end
                    q1.push_back(w1);
                    q0.push_back(w0);
                    part.delete();
                end
            end
            if (b1.m_tvalid && b1.m_tready) begin
                if (q1.size() == 0) begin
                    n_total++;
                    $display("FAIL sb1_unexpected: got word 0x%0h, required none", b1.m_tdata);
                end else begin
                    e1 = q1.pop_front();
                    check("sb1_data", b1.m_tdata, e1.d);
                    check("sb1_keep", b1.m_tkeep, e1.k);
                    check("sb1_last", b1.m_tlast, e1.l);
                end
            end
            if (b0.m_tvalid && b0.m_tready) begin
                if (q0.size() == 0) begin
                    n_total++;
                    $display("FAIL sb0_unexpected: got word 0x%0h, required none", b0.m_tdata);
                end else begin
                    e0 = q0.pop_front();
                    check("sb0_data", b0.m_tdata, e0.d);
                    check("sb0_keep", b0.m_tkeep, e0.k);
                    check("sb0_last", b0.m_tlast, e0.l);
                end
            end
            stall1 = b1.m_tvalid && !b1.m_tready;
            held1  = '{b1.m_tdata, b1.m_tkeep, b1.m_tlast};
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        int          n;
        logic [31:0] bp;    // beat j in bp[8j +: 8]
        logic        last;
        logic [31:0] d1;
        logic [3:0]  k1;
        logic [31:0] d0;
        logic [3:0]  k0;
    } vec_t;

    vec_t vt[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        v, l, holding;
        logic [7:0]  d;

        vt[0] = '{4, 32'h6F6C6568, 1'b1, 32'h6F6C6568, 4'hF, 32'h68656C6F, 4'hF};
        vt[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3, 32'hAABB0000, 4'hC};
        vt[2] = '{4, 32'h44332211, 1'b1, 32'h44332211, 4'hF, 32'h11223344, 4'hF};
        vt[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 32'h5A000000, 4'h8};
        vt[4] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7, 32'h01020300, 4'hE};
        vt[5] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'hF, 32'hDEADBEEF, 4'hF};

        stall_cnt = 0;
        set_ready(1'b1);
        drive(1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", b1.m_tvalid, 1'b0);
        check("rst_m_tdata", b1.m_tdata, 32'h0);
        check("rst_m_tkeep", b1.m_tkeep, 4'h0);
        check("rst_m_tlast", b1.m_tlast, 1'b0);
        check("rst_s_tready", b1.s_tready, 1'b0);
        check("rst_m_tvalid0", b0.m_tvalid, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vt[i].n; j++)
                send_beat(vt[i].bp[8*j +: 8], (j == vt[i].n - 1) ? vt[i].last : 1'b0);
            drive(1'b0, 8'h00, 1'b0);
            check($sformatf("vec%0d_valid1", i), b1.m_tvalid, 1'b1);
            check($sformatf("vec%0d_data1", i), b1.m_tdata, vt[i].d1);
            check($sformatf("vec%0d_keep1", i), b1.m_tkeep, vt[i].k1);
            check($sformatf("vec%0d_last1", i), b1.m_tlast, vt[i].last);
            check($sformatf("vec%0d_valid0", i), b0.m_tvalid, 1'b1);
            check($sformatf("vec%0d_data0", i), b0.m_tdata, vt[i].d0);
            check($sformatf("vec%0d_keep0", i), b0.m_tkeep, vt[i].k0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_one_cycle1", i), b1.m_tvalid, 1'b0);
            check($sformatf("vec%0d_one_cycle0", i), b0.m_tvalid, 1'b0);
        end

        // Backpressure: word held 5 cycles with a beat waiting, then released.
        set_ready(1'b0);
        for (int j = 0; j < 4; j++) send_beat(8'h10 + 8'(j), j == 3);
        drive(1'b1, 8'h20, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp_s_tready", b1.s_tready, 1'b0);
            check("bp_m_tvalid", b1.m_tvalid, 1'b1);
            check("bp_m_tdata", b1.m_tdata, 32'h13121110);
            @(posedge clk); #1;
        end
        set_ready(1'b1);
        for (int j = 0; j < 4; j++) send_beat(8'h20 + 8'(j), j == 3);
        drive(1'b0, 8'h00, 1'b0);
        check("bp_next_data1", b1.m_tdata, 32'h23222120);
        check("bp_next_data0", b0.m_tdata, 32'h20212223);
        check("bp_next_last", b1.m_tlast, 1'b1);
        @(posedge clk); #1;

        // Streaming: 8 beats back to back, no stalls expected.
        stall_cnt = 0;
        for (int j = 1; j <= 8; j++) send_beat(8'(j), j == 8);
        drive(1'b0, 8'h00, 1'b0);
        check("stream_stalls", stall_cnt, 0);
        check("stream_data2", b1.m_tdata, 32'h08070605);
        check("stream_last2", b1.m_tlast, 1'b1);
        @(posedge clk); #1;

        // Reset while a word is held: outputs clear without waiting for a clock.
        set_ready(1'b0);
        for (int j = 0; j < 4; j++) send_beat(8'hA1 + 8'(j), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("rsta_held", b1.m_tvalid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rsta_m_tvalid", b1.m_tvalid, 1'b0);
        check("rsta_m_tdata", b1.m_tdata, 32'h0);
        check("rsta_m_tkeep", b1.m_tkeep, 4'h0);
        check("rsta_s_tready", b1.s_tready, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_ready(1'b1);
        @(posedge clk); #1;

        // Reset mid-word: two buffered beats must be discarded.
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rstb_s_tready", b1.s_tready, 1'b0);
        check("rstb_m_tvalid", b1.m_tvalid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int j = 1; j <= 4; j++) send_beat(8'(j), j == 4);
        drive(1'b0, 8'h00, 1'b0);
        check("rstb_data1", b1.m_tdata, 32'h04030201);
        check("rstb_keep1", b1.m_tkeep, 4'hF);
        check("rstb_data0", b0.m_tdata, 32'h01020304);
        @(posedge clk); #1;

        // Random phase against the reference model.
        holding = 1'b0;
        v = 1'b0; d = 8'h00; l = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!holding) begin
                v = ($urandom_range(0, 9) < 7);
                d = 8'($urandom);
                l = ($urandom_range(0, 3) == 0);
            end
            set_ready($urandom_range(0, 9) < 7);
            drive(v, d, l);
            @(negedge clk);
            holding = v && !b1.s_tready;
            @(posedge clk); #1;
        end
        set_ready(1'b1);
        send_beat(8'($urandom), 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("sb1_drained", q1.size(), 0);
        check("sb0_drained", q0.size(), 0);
        check("sb_partial_empty", part.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Parametrised AXI-Stream width up-converter. Packs RATIO narrow input beats of DW_IN bits into one output word of DW_IN*RATIO bits.
- Next generation of the stream register block: adds full two-sided handshake (m_tready backpressure), packet framing via tlast, per-lane byte-keep for partial words, and selectable lane order.
- Sits between a narrow producer (e.g. byte source) and a wide consumer/DMA stream port.

Parameters:
- DW_IN, 8: input data width in bits; must be >= 1.
- RATIO, 4: input beats per output word; must be >= 1. DW_OUT = DW_IN*RATIO is derived and is not a parameter.
- LSB_FIRST, 1: 1 = first beat of a word goes to lane 0 (bits DW_IN-1:0); 0 = first beat goes to lane RATIO-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_tdata  in  DW_IN  input beat data.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat ready.
- s_tlast  in  1  marks the last beat of a packet.
- m_tdata  out  DW_IN*RATIO  packed output word.
- m_tkeep  out  RATIO  one bit per lane; 1 = lane holds a real beat.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  output word ends a packet.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous): m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0; lane index idx=0; accumulator data and keep cleared.
- While reset_n is low, s_tready=0.
- Input accept: a beat transfers when s_tvalid && s_tready.
- s_tready = reset_n && (!m_tvalid || m_tready). This is a combinational path from m_tready and is documented as such.
- Lane placement:
  - Accepted beat is written to lane L = idx if LSB_FIRST, else RATIO-1-idx.
  - Lane L occupies m_tdata[L*DW_IN +: DW_IN]; keep bit L is set.
- Word completion: a word completes when an accepted beat has idx==RATIO-1 or s_tlast==1.
- On the completing beat:
  - The full word (accumulator merged with the current beat) loads the output register.
  - m_tvalid=1 on the next cycle; latency is 1 cycle from the completing beat to m_tvalid.
  - m_tlast = s_tlast of that beat.
  - idx returns to 0 and the accumulator clears.
- Non-completing beat: idx increments and the beat is stored in the accumulator; the output register is unaffected.
- Partial word (s_tlast before lane RATIO-1 is filled): unfilled lanes are driven 0 and their m_tkeep bits are 0.
- Output hold: while m_tvalid && !m_tready, m_tdata, m_tkeep and m_tlast hold stable and s_tready=0, so no beats are accepted.
- Output drain: m_tvalid clears after m_tvalid && m_tready unless a new word completes in the same cycle.
- Simultaneous drain and complete: if a word drains and another completes in the same cycle, the new word loads and m_tvalid stays 1. Sustained throughput is 1 input beat/cycle.
- s_tvalid low mid-word: the accumulator holds indefinitely; there is no timeout.
- RATIO=1: behaves as a 1-stage registered pipe with m_tkeep=1'b1 and m_tlast=s_tlast.
- Reset mid-packet: the partial accumulator is discarded and the output word is dropped; the first beat after reset starts a new word at idx 0.
- idx width is clog2(RATIO), minimum 1. idx never exceeds RATIO-1 because of the completion rule.

Decomposition:
- Shared package axis_pkg holds:
  - function clog2_min1 (idx width).
  - localparam helper for the DW_OUT computation.
  - lane-index mapping function lane_of(idx, LSB_FIRST, RATIO).
- One natural sub-module: axis_out_reg, the output holding register with valid/ready hold logic, generic in width (data+keep+last). The packing datapath stays in the top.

Test Plan (DW_IN=8, RATIO=4, LSB_FIRST=1 unless noted):
- Full word, m_tready=1: beats 0x68,0x65,0x6C,0x6F, last on the 4th -> one cycle later m_tdata=0x6F6C6568, m_tkeep=4'b1111, m_tlast=1, m_tvalid high for 1 cycle.
- Partial packet: beats 0xAA,0xBB, last on the 2nd -> m_tdata=0x0000BBAA, m_tkeep=4'b0011, m_tlast=1.
- Backpressure: hold m_tready=0 for 5 cycles with the word valid -> s_tready=0 and m_tdata stable for 5 cycles. Release -> word transfers once, with no duplicate and no loss across the next word.
- Streaming: 8 consecutive beats 0x01..0x08, s_tlast on the 8th, m_tready=1 -> words 0x04030201 (m_tlast=0) then 0x08070605 (m_tlast=1), no stall cycles on s_tready.
- Lane order with LSB_FIRST=0: beats 0x11,0x22,0x33,0x44 -> m_tdata=0x11223344, m_tkeep=4'b1111.
- Reset mid-word: 2 beats accepted, then reset_n pulsed low 1 cycle -> outputs all 0 immediately. Next beats 0x01,0x02,0x03,0x04 -> m_tdata=0x04030201 with no stale lanes.
